seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver. Samples the active-low anode (AN) and cathode (CA) lines of a 4-digit scanned display, waits for each digit phase to settle, and decodes every segment pattern back to a hex nibble. Assembles a full 4-digit frame with a valid/ready handshake. Used for on-board loopback checking and for capturing display output in system benches.

Parameters:
SETTLE_CYCLES, 16, clk cycles the synchronized AN/CA must stay unchanged before a digit is captured (range 1..255)
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
an_in  input  4  anode lines, active-low, asynchronous to clk
ca_in  input  8  cathode lines, active-low; bit7 = dp, bits6:0 = g..a
digits  output  16  decoded nibbles; [3:0] = digit0 (AN[0]) ... [15:12] = digit3
dp  output  4  decimal-point state per digit, 1 = lit
blank  output  4  per digit, 1 = all segments off (pattern 7'h7F)
seg_err  output  4  per digit, 1 = pattern not in decode table
frame_valid  output  1  frame outputs valid
frame_ready  input  1  consumer accepts frame
overrun  output  1  sticky; a frame completed while the previous one was unconsumed

Behaviour:
- Reset (clr_n low, async): all outputs 0. Synchronizers hold AN = 4'hF and CA = 8'hFF. State IDLE. Counter 0. seen_mask 0.
- Input sync: a 2-flop synchronizer on all 12 lines. All later logic uses only the synchronized values.
- Phase detect: a phase is valid only if exactly one synchronized AN bit is 0. Any other AN value means no phase.
- FSM:
  - IDLE: on a valid phase -> SETTLE, counter = 0.
  - SETTLE: if AN or CA differs from the previous cycle -> restart counter (-> IDLE if no valid phase). Otherwise counter++. When counter reaches SETTLE_CYCLES-1 -> capture -> CAPTURED.
  - CAPTURED: stay until AN changes. Then -> SETTLE if the new value is a valid phase, else -> IDLE. A CA change alone in CAPTURED is ignored (no recapture).
- Latency: an AN/CA edge to capture = 2 (sync) + SETTLE_CYCLES clk cycles.
- Capture decode table (CA[6:0] active-low -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
- Capture side effects:
  - dp bit = ~CA[7].
  - 7F: blank = 1, nibble = 0.
  - Any other code not in the table: seg_err = 1, nibble = 0.
  - Results go into shadow registers for the phase's digit; seen_mask bit set.
  - Recapturing a digit already seen in the current frame overwrites its shadow; seen_mask is unchanged.
- Frame completion: when seen_mask becomes 4'hF, the shadow is copied to the outputs if a load is allowed.
  - Load allowed when frame_valid = 0, or frame_valid & frame_ready in the same cycle.
  - On load: frame_valid = 1 next cycle; seen_mask cleared.
  - Load not allowed: frame dropped, outputs unchanged, overrun set (sticky until reset), seen_mask cleared.
- Handshake:
  - frame_valid & frame_ready with no completion that cycle -> frame_valid = 0 next cycle.
  - Outputs stay stable while frame_valid = 1.
- Reset mid-operation: everything returns to reset values immediately. A partial frame is discarded.

Optional Feature:
Macro SEG7_ERR_COUNT_EN.
- Defined: adds output err_count[7:0]. It increments once per capture with seg_err or with a no-phase AN glitch (AN not 4'hF and not one-hot) lasting ≥1 synchronized cycle. It saturates at 8'hFF and resets to 0.
- Not defined: the port and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Scan AN 1110/1101/1011/0111, CA = 40/79/24/30 (dp off), 40 cycles per phase, frame_ready = 1 -> frame_valid pulses 1 cycle; digits = 16'h3210, dp = 0, blank = 0, seg_err = 0.
- Same scan with CA changing every 8 cycles inside phase 0 (SETTLE_CYCLES = 16) -> no capture of digit0 until CA is stable; frame completes only after a stable 18+ cycle window.
- frame_ready = 0, drive two full frames (8,9,A,b then C,d,E,F) -> digits = 16'hbA98 held, frame_valid = 1, overrun = 1; then frame_ready = 1 -> frame_valid drops next cycle.
- Digit2 CA = 7F, digit3 CA = 55 with dp lit (CA[7] = 0) -> blank = 4'b0100, seg_err = 4'b1000, dp = 4'b1000, digits[15:8] = 8'h00.
- Assert clr_n low mid-frame after 2 digits, release, scan a full frame -> no stale digits; first frame_valid appears only after all 4 new phases.
- SEG7_ERR_COUNT_EN defined: AN = 1100 for 5 cycles, plus one CA = 55 capture -> err_count = 2.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - Scanned 7-segment display capture and hex frame assembly
// Optional feature macro: SEG7_ERR_COUNT_EN (adds saturating err_count output).
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  an_in,
    input  logic [7:0]  ca_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    // {err, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {2'b00, 4'h0};
            7'h79:   decode = {2'b00, 4'h1};
            7'h24:   decode = {2'b00, 4'h2};
            7'h30:   decode = {2'b00, 4'h3};
            7'h19:   decode = {2'b00, 4'h4};
            7'h12:   decode = {2'b00, 4'h5};
            7'h02:   decode = {2'b00, 4'h6};
            7'h78:   decode = {2'b00, 4'h7};
            7'h00:   decode = {2'b00, 4'h8};
            7'h10:   decode = {2'b00, 4'h9};
            7'h08:   decode = {2'b00, 4'hA};
            7'h03:   decode = {2'b00, 4'hB};
            7'h46:   decode = {2'b00, 4'hC};
            7'h21:   decode = {2'b00, 4'hD};
            7'h06:   decode = {2'b00, 4'hE};
            7'h0E:   decode = {2'b00, 4'hF};
            7'h7F:   decode = {2'b01, 4'h0};
            default: decode = {2'b10, 4'h0};
        endcase
    endfunction

    logic [3:0]       an_meta_q, an_meta_d, an_sync_q, an_sync_d, an_prev_q, an_prev_d;
    logic [7:0]       ca_meta_q, ca_meta_d, ca_sync_q, ca_sync_d, ca_prev_q, ca_prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      sh_dig_q, sh_dig_d, digits_q, digits_d;
    logic [3:0]       sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
    logic [3:0]       seen_q, seen_d, dp_q, dp_d, blank_q, blank_d, seg_err_q, seg_err_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    logic [3:0]       an_low;
    logic             phase_ok, an_changed, any_changed, capture, complete;
    logic [5:0]       dec;

    assign an_low      = ~an_sync_q;
    assign phase_ok    = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
    assign an_changed  = an_sync_q != an_prev_q;
    assign any_changed = an_changed || (ca_sync_q != ca_prev_q);
    assign dec         = decode(ca_sync_q[6:0]);

    always_comb begin
        an_meta_d = an_in;
        ca_meta_d = ca_in;
        an_sync_d = an_meta_q;
        ca_sync_d = ca_meta_q;
        an_prev_d = an_sync_q;
        ca_prev_d = ca_sync_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (phase_ok) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (any_changed) begin
                    cnt_d = '0;
                    if (!phase_ok) state_d = IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = CAPTURED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURED: begin
                // Only an anode change ends the phase; cathode churn is ignored here.
                if (an_changed) begin
                    cnt_d   = '0;
                    state_d = phase_ok ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_dig_d   = sh_dig_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        sh_err_d   = sh_err_q;
        seen_d     = seen_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        seg_err_d  = seg_err_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        complete   = 1'b0;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (!an_sync_q[i]) begin
                    sh_dig_d[i*4 +: 4] = dec[3:0];
                    sh_dp_d[i]         = ~ca_sync_q[7];
                    sh_blank_d[i]      = dec[4];
                    sh_err_d[i]        = dec[5];
                    seen_d[i]          = 1'b1;
                end
            end
            complete = (seen_d == 4'hF);
        end
        if (valid_q && frame_ready) valid_d = 1'b0;
        if (complete) begin
            seen_d = 4'h0;
            if (!valid_q || frame_ready) begin
                digits_d  = sh_dig_d;
                dp_d      = sh_dp_d;
                blank_d   = sh_blank_d;
                seg_err_d = sh_err_d;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an_meta_q  <= 4'hF;
            an_sync_q  <= 4'hF;
            an_prev_q  <= 4'hF;
            ca_meta_q  <= 8'hFF;
            ca_sync_q  <= 8'hFF;
            ca_prev_q  <= 8'hFF;
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_dig_q   <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_err_q   <= '0;
            seen_q     <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            seg_err_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            an_meta_q  <= an_meta_d;
            an_sync_q  <= an_sync_d;
            an_prev_q  <= an_prev_d;
            ca_meta_q  <= ca_meta_d;
            ca_sync_q  <= ca_sync_d;
            ca_prev_q  <= ca_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_dig_q   <= sh_dig_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            sh_err_q   <= sh_err_d;
            seen_q     <= seen_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            seg_err_q  <= seg_err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = valid_q;
    assign overrun     = overrun_q;

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_inc;

    // A glitch is counted once, on the cycle the synchronized anode enters it.
    assign err_inc = (capture && dec[5]) ||
                     (an_changed && (an_sync_q != 4'hF) && !phase_ok);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'h01;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - Randomized phase-level model check of seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  an_in = 4'hF;
    logic [7:0]  ca_in = 8'hFF;
    logic        frame_ready = 1'b1;
    logic [15:0] digits;
    logic [3:0]  dp, blank, seg_err;
    logic        frame_valid, overrun;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    seg7_scan_decoder #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .an_in(an_in), .ca_in(ca_in),
        .digits(digits), .dp(dp), .blank(blank), .seg_err(seg_err),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
`ifdef SEG7_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [27:0] exp_q [$];
    logic [27:0] last_obs;

    logic [3:0]  m_dig [4];
    logic [3:0]  m_dp, m_bl, m_er, m_seen;
    logic        m_valid, m_ovr, m_holding;
    logic [3:0]  m_prev_an;
    logic [7:0]  m_prev_ca;
    int          m_errs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
                check("frame_contents", {4'h0, digits, dp, blank, seg_err}, {4'h0, exp_q[0]});
                if (frame_ready) begin
                    last_obs = {digits, dp, blank, seg_err};
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dp = 0; m_bl = 0; m_er = 0; m_seen = 0;
        m_valid = 0; m_ovr = 0; m_holding = 0; m_errs = 0;
        m_prev_an = 4'hF; m_prev_ca = 8'hFF;
        exp_q.delete();
    endtask

    task automatic do_reset();
        clr_n = 1'b0; an_in = 4'hF; ca_in = 8'hFF; frame_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", {16'h0, digits}, 32'h0);
        check("reset_flags", {20'h0, dp, blank, seg_err}, 32'h0);
        check("reset_valid", {31'h0, frame_valid}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
`ifdef SEG7_ERR_COUNT_EN
        check("reset_err_count", {24'h0, err_count}, 32'h0);
`endif
        clr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One stable (an, ca) segment held for dur cycles; the model decides its fate from the scan rules.
    task automatic run_seg(input logic [3:0] an, input logic [7:0] ca, input int dur, input logic rdy);
        logic [3:0] low;
        logic       ph, cap, hit;
        logic [3:0] nib;
        int         idx;
        low = ~an;
        ph  = (low != 0) && ((low & (low - 4'h1)) == 0);
        if (an != m_prev_an) begin
            m_holding = 0;
            if (an != 4'hF && !ph && m_errs < 255) m_errs++;
        end
        cap = ph && (dur > S) && !m_holding;
        if (rdy) m_valid = 0;
        if (cap) begin
            m_holding = 1;
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            hit = 0; nib = 0;
            for (int n = 0; n < 16; n++) if (seg_tab[n] == ca[6:0]) begin hit = 1; nib = 4'(n); end
            m_dig[idx]  = nib;
            m_dp[idx]   = ~ca[7];
            m_bl[idx]   = (ca[6:0] == 7'h7F);
            m_er[idx]   = !hit && (ca[6:0] != 7'h7F);
            m_seen[idx] = 1;
            if (m_er[idx] && m_errs < 255) m_errs++;
            if (m_seen == 4'hF) begin
                if (m_valid && !rdy) m_ovr = 1;
                else begin
                    exp_q.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp, m_bl, m_er});
                    m_valid = !rdy;
                end
                m_seen = 0;
            end
        end
        m_prev_an = an; m_prev_ca = ca;
        an_in = an; ca_in = ca; frame_ready = rdy;
        repeat (dur) @(posedge clk);
        #1;
        check("seg_end_overrun", {31'h0, overrun}, {31'h0, m_ovr});
        check("seg_end_frame_valid", {31'h0, frame_valid}, {31'h0, m_valid});
    endtask

    task automatic scan4(input logic [7:0] c0, c1, c2, c3, input logic rdy);
        run_seg(4'hE, c0, 40, rdy);
        run_seg(4'hD, c1, 40, rdy);
        run_seg(4'hB, c2, 40, rdy);
        run_seg(4'h7, c3, 40, rdy);
    endtask

    initial begin
        int p;
        logic [3:0] an;
        logic [7:0] ca;
        int dur;
        do_reset();

        scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b1);
        check("basic_frame", {4'h0, last_obs}, {4'h0, 16'h3210, 12'h000});

        p = n_pops;
        for (int k = 0; k < 4; k++) run_seg(4'hE, (k % 2 == 0) ? 8'hC0 : 8'hC1, 8, 1'b1);
        check("no_early_capture", p, n_pops);
        run_seg(4'hE, 8'hC0, 40, 1'b1);
        run_seg(4'hD, 8'hF9, 40, 1'b1);
        run_seg(4'hB, 8'hA4, 40, 1'b1);
        run_seg(4'h7, 8'hB0, 40, 1'b1);
        check("settled_frame", {4'h0, last_obs}, {4'h0, 16'h3210, 12'h000});

        scan4(8'hC0, 8'hF9, 8'hFF, 8'h55, 1'b1);
        check("blank_err_dp_frame", {4'h0, last_obs}, {4'h0, 16'h0010, 4'b1000, 4'b0100, 4'b1000});

        scan4(8'h80, 8'h90, 8'h88, 8'h83, 1'b0);
        scan4(8'hC6, 8'hA1, 8'h86, 8'h8E, 1'b0);
        check("held_digits", {16'h0, digits}, 32'h0000_BA98);
        check("held_valid", {31'h0, frame_valid}, 32'd1);
        check("overrun_set", {31'h0, overrun}, 32'd1);
        frame_ready = 1'b1;
        m_valid = 0;
        @(posedge clk);
        #1;
        check("valid_drops", {31'h0, frame_valid}, 32'd0);

        run_seg(4'hE, 8'hC0, 40, 1'b1);
        run_seg(4'hD, 8'hF9, 40, 1'b1);
        do_reset();
        p = n_pops;
        run_seg(4'hB, 8'h92, 40, 1'b1);
        run_seg(4'h7, 8'h99, 40, 1'b1);
        run_seg(4'hE, 8'hF8, 40, 1'b1);
        check("no_stale_frame", p, n_pops);
        run_seg(4'hD, 8'h82, 40, 1'b1);
        check("post_reset_frame_count", p + 1, n_pops);
        check("post_reset_frame", {4'h0, last_obs}, {4'h0, 16'h4567, 12'h000});

        for (int k = 0; k < 160; k++) begin
            p = $urandom_range(0, 9);
            if (p < 8) an = ~(4'h1 << $urandom_range(0, 3));
            else       an = 4'($urandom_range(0, 15));
            p = $urandom_range(0, 9);
            if (p < 7)      ca = {1'b0, seg_tab[$urandom_range(0, 15)]};
            else if (p < 8) ca = 8'h7F;
            else            ca = 8'($urandom_range(0, 127));
            ca[7] = 1'($urandom_range(0, 1));
            if (an == m_prev_an && ca == m_prev_ca) ca[7] = ~ca[7];
            dur = ($urandom_range(0, 9) < 6) ? $urandom_range(S + 8, S + 20) : $urandom_range(1, S - 2);
            run_seg(an, ca, dur, $urandom_range(0, 9) < 7);
        end

        run_seg((m_prev_an == 4'hF) ? 4'hE : 4'hF, 8'hFF, 40, 1'b1);
        check("all_frames_consumed", exp_q.size(), 0);
`ifdef SEG7_ERR_COUNT_EN
        check("err_count", {24'h0, err_count}, 32'(m_errs));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
